vga_vblank_write_arbiter: RTL and testbench
===========================================

Name: vga_vblank_write_arbiter

Overview:
- Shares the write port of the sprite/position register RAM among game-logic requesters (mole controller, hammer cursor, score).
- Writes are allowed only inside a blanking window derived from the VGA timing counters, so the pixel renderer never reads a half-updated frame.
- Round-robin arbitration with a single-beat req/grant handshake; a frame tick is emitted at the start of vertical blanking.
- Sits between the game FSMs and the sprite RAM, and is fed hcounter/vcounter from the VGA timing driver.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- ADDR_W, 6, RAM address width
- DATA_W, 16, RAM data width
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, pixels per line including blanking
- V_ACTIVE, 480, visible lines per frame
- V_TOTAL, 525, lines per frame including blanking
- GUARD_LINES, 2, lines at the end of vblank in which no new grant is issued
- H_GUARD, 4, pixel clocks at the end of hblank in which no new grant is issued (used only with the optional feature)

Ports:
- clk, input, 1, pixel clock
- rst, input, 1, synchronous active-high reset
- hcounter, input, 10, horizontal position from the timing driver
- vcounter, input, 10, vertical position from the timing driver
- req, input, N_REQ, per-requester write request (level)
- req_addr, input, N_REQ*ADDR_W, packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_data, input, N_REQ*DATA_W, packed data; requester i uses bits [i*DATA_W +: DATA_W]
- grant, output, N_REQ, one-hot one-cycle write acknowledge
- mem_we, output, 1, RAM write enable
- mem_addr, output, ADDR_W, RAM write address
- mem_wdata, output, DATA_W, RAM write data
- frame_tick, output, 1, one-cycle pulse at the start of vblank
- late, output, 1, one-cycle pulse when a request is still pending at frame_tick

Behaviour:
- Reset values: grant=0, mem_we=0, mem_addr=0, mem_wdata=0, frame_tick=0, late=0. FSM=ARB. The round-robin pointer is set so requester 0 has top priority.
- Interface: one clock (clk); synchronous active-high reset (rst).
- Window: win = (vcounter >= V_ACTIVE) && (vcounter < V_TOTAL-GUARD_LINES). Evaluated combinationally from the inputs.
- FSM states: ARB and WRITE.
- ARB: if win and |req, pick the first requester with req set, searching from (last_winner+1) mod N_REQ upward with wrap. Register its index, addr and data, then go to WRITE. Otherwise stay in ARB with all outputs 0.
- WRITE: lasts exactly one cycle. grant[winner]=1, mem_we=1, mem_addr/mem_wdata hold the captured values. last_winner is updated to winner. Next state is always ARB.
- Latency: req sampled high at edge k in ARB gives grant/mem_we high in cycle k+1. Peak throughput is one write per 2 clocks.
- Handshake: a requester holds req, addr and data stable until it sees grant. The write is complete in the grant cycle. To issue another write, keep req high (new addr/data allowed from the cycle after grant). Dropping req before grant is not permitted.
- Window closes while in WRITE: the write still completes, and no further grant is issued until the window reopens.
- Simultaneous requests: strict rotation, so each of K continuous requesters is granted once in every K grants.
- frame_tick: registered. High for exactly one cycle, the cycle after the inputs show hcounter==H_TOTAL-1 and vcounter==V_ACTIVE-1.
- late: asserted in the same cycle as frame_tick if |req was high when frame_tick's condition was sampled.
- rst asserted mid-WRITE: the next cycle shows all outputs 0. A pending request is re-arbitrated after reset from priority 0.
- Address/data are passed through unmodified with no width conversion.

Optional Feature:
- Macro: VGA_ARB_HBLANK_EN.
- Defined: the window additionally opens on active lines when (hcounter >= H_ACTIVE) && (hcounter < H_TOTAL-H_GUARD), i.e. win = vblank term OR hblank term.
- Undefined: vblank-only window exactly as in Behaviour; H_GUARD is ignored.

Test Plan:
- Reset, then vcounter=100, hcounter=10, req=3'b001 → no grant, mem_we=0 while vcounter<480. At vcounter=480: grant=3'b001 one cycle after req is sampled; mem_addr/mem_wdata equal requester 0's values.
- req=3'b111 held continuously in vblank → grant sequence 001,100? no: 001,010,100,001 with one idle (ARB) cycle between each grant.
- Request raised at vcounter=523 (V_TOTAL-GUARD_LINES) → no grant until vcounter=480 of the next frame. late pulses with frame_tick at that vblank start.
- Grant issued on the last window cycle (vcounter=522, hcounter=799) → WRITE completes on vcounter=523; no second grant.
- rst pulsed during WRITE with req=3'b100 → outputs 0 the next cycle; afterwards requester 2 is granted.
- With VGA_ARB_HBLANK_EN: vcounter=100, hcounter=650, req=3'b010 → grant=3'b010 next cycle. At hcounter=796 → no grant. Without the macro → no grant on line 100.

Source files
------------

// File: rtl/vga_vblank_write_arbiter_if.sv
// Write-request bus between the game requesters and the blanking-window arbiter,
// plus the VGA timing counters and frame/late status outputs.
interface vga_vblank_write_arbiter_if #(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16
);
   logic [9:0]             hcounter;
   logic [9:0]             vcounter;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        grant;
   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_addr;
   logic [DATA_W-1:0]       mem_wdata;
   logic                    frame_tick;
   logic                    late;

   modport master (
      output hcounter, vcounter, req, req_addr, req_data,
      input  grant, mem_we, mem_addr, mem_wdata, frame_tick, late
   );

   modport slave (
      input  hcounter, vcounter, req, req_addr, req_data,
      output grant, mem_we, mem_addr, mem_wdata, frame_tick, late
   );
endinterface

// File: rtl/vga_vblank_write_arbiter.sv
// Round-robin sprite-RAM write arbiter that only grants inside the VGA blanking window.
// Optional macro VGA_ARB_HBLANK_EN also opens the window during hblank of active lines.
//
// state    | meaning
// ARB      | idle / choosing the next winner while the window is open
// WRITE    | one-cycle RAM write and grant to the captured winner
module vga_vblank_write_arbiter #(
   parameter int N_REQ       = 3,
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 16,
   parameter int H_ACTIVE    = 640,
   parameter int H_TOTAL     = 800,
   parameter int V_ACTIVE    = 480,
   parameter int V_TOTAL     = 525,
   parameter int GUARD_LINES = 2,
   parameter int H_GUARD     = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   vga_vblank_write_arbiter_if.slave    bus
);
   localparam int IDX_W = $clog2(N_REQ);

   localparam logic [0:0] ST_ARB   = 1'b0;
   localparam logic [0:0] ST_WRITE = 1'b1;

   localparam logic [9:0] V_ACT_C     = 10'(V_ACTIVE);
   localparam logic [9:0] V_WIN_END_C = 10'(V_TOTAL - GUARD_LINES);
   localparam logic [9:0] V_LAST_C    = 10'(V_ACTIVE - 1);
   localparam logic [9:0] H_LAST_C    = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_ACT_C     = 10'(H_ACTIVE);
   localparam logic [9:0] H_WIN_END_C = 10'(H_TOTAL - H_GUARD);

   // Last winner resets to the top index so the first search starts at requester 0.
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("N_REQ must be in 2..8");
   end
   if (H_GUARD >= H_TOTAL - H_ACTIVE) begin : g_bad_hguard
      $error("H_GUARD must leave part of hblank open");
   end

   logic [0:0]        state_q, state_d;
   logic [IDX_W-1:0]  winner_q, winner_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              frame_tick_q, frame_tick_d;
   logic              late_q, late_d;

   logic              win;
   logic              found;
   logic [IDX_W-1:0]  pick;
   int                idx;

   always_comb begin
      win = (bus.vcounter >= V_ACT_C) && (bus.vcounter < V_WIN_END_C);
`ifdef VGA_ARB_HBLANK_EN
      if ((bus.vcounter < V_ACT_C) && (bus.hcounter >= H_ACT_C) && (bus.hcounter < H_WIN_END_C)) begin
         win = 1'b1;
      end
`endif
   end

   // Search starts just past the last winner and wraps, giving strict rotation.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(last_q) + 1 + i) % N_REQ;
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            pick  = IDX_W'(idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      last_d   = last_q;
      addr_d   = addr_q;
      data_d   = data_q;
      case (state_q)
         ST_ARB: begin
            if (win && found) begin
               state_d  = ST_WRITE;
               winner_d = pick;
               addr_d   = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
               data_d   = bus.req_data[int'(pick)*DATA_W +: DATA_W];
            end
         end
         ST_WRITE: begin
            state_d = ST_ARB;
            last_d  = winner_q;
         end
         default: state_d = ST_ARB;
      endcase
   end

   always_comb begin
      frame_tick_d = (bus.hcounter == H_LAST_C) && (bus.vcounter == V_LAST_C);
      late_d       = frame_tick_d && (|bus.req);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_ARB;
         winner_q     <= '0;
         last_q       <= LAST_RST;
         addr_q       <= '0;
         data_q       <= '0;
         frame_tick_q <= 1'b0;
         late_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         winner_q     <= winner_d;
         last_q       <= last_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         frame_tick_q <= frame_tick_d;
         late_q       <= late_d;
      end
   end

   assign bus.grant      = (state_q == ST_WRITE) ? (N_REQ'(1) << winner_q) : '0;
   assign bus.mem_we     = (state_q == ST_WRITE);
   assign bus.mem_addr   = (state_q == ST_WRITE) ? addr_q : '0;
   assign bus.mem_wdata  = (state_q == ST_WRITE) ? data_q : '0;
   assign bus.frame_tick = frame_tick_q;
   assign bus.late       = late_q;
endmodule

// File: tb/tb_vga_vblank_write_arbiter.sv
// Scoreboard bench for vga_vblank_write_arbiter: directed stimulus pushes expected
// grants/ticks with their cycle number, a negedge monitor pops and compares.
module tb_vga_vblank_write_arbiter;
   localparam logic [5:0]  A0 = 6'h11, A1 = 6'h22, A2 = 6'h33;
   localparam logic [15:0] D0 = 16'h1234, D1 = 16'hBEEF, D2 = 16'hC0DE;

   typedef struct {
      int          cyc;
      logic [2:0]  g;
      logic [5:0]  a;
      logic [15:0] d;
   } gexp_t;

   typedef struct {
      int   cyc;
      logic lt;
   } texp_t;

   logic clk;
   logic rst;
   int   cyc_cnt;
   int   n_pass;
   int   n_total;
   gexp_t gq[$];
   texp_t tq[$];

   vga_vblank_write_arbiter_if #(.N_REQ(3), .ADDR_W(6), .DATA_W(16)) bus ();

   vga_vblank_write_arbiter #(
      .N_REQ(3), .ADDR_W(6), .DATA_W(16),
      .H_ACTIVE(640), .H_TOTAL(800), .V_ACTIVE(480), .V_TOTAL(525),
      .GUARD_LINES(2), .H_GUARD(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_g(input int at, input logic [2:0] g, input logic [5:0] a, input logic [15:0] d);
      gexp_t e;
      e.cyc = at; e.g = g; e.a = a; e.d = d;
      gq.push_back(e);
   endtask

   task automatic push_t(input int at, input logic lt);
      texp_t e;
      e.cyc = at; e.lt = lt;
      tq.push_back(e);
   endtask

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1 || (bus.grant !== 3'b000 && bus.grant !== 3'bxxx)) begin
         if (gq.size() == 0) begin
            chk("unexpected_write", 32'(bus.mem_we), 32'd0);
         end else begin
            gexp_t e;
            e = gq.pop_front();
            chk("grant_cycle", cyc_cnt, e.cyc);
            chk("grant", 32'(bus.grant), 32'(e.g));
            chk("mem_we", 32'(bus.mem_we), 32'd1);
            chk("mem_addr", 32'(bus.mem_addr), 32'(e.a));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.d));
         end
      end
      if (bus.frame_tick === 1'b1) begin
         if (tq.size() == 0) begin
            chk("unexpected_tick", 32'(bus.frame_tick), 32'd0);
         end else begin
            texp_t t;
            t = tq.pop_front();
            chk("tick_cycle", cyc_cnt, t.cyc);
            chk("late", 32'(bus.late), 32'(t.lt));
         end
      end else if (bus.late === 1'b1) begin
         chk("late_without_tick", 32'(bus.late), 32'd0);
      end
   end

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst = 1'b1;
      bus.hcounter = 10'd0;
      bus.vcounter = 10'd0;
      bus.req      = 3'b000;
      bus.req_addr = {A2, A1, A0};
      bus.req_data = {D2, D1, D0};

      // reset state
      cyc(); cyc();
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      chk("rst_frame_tick", 32'(bus.frame_tick), 32'd0);
      chk("rst_late", 32'(bus.late), 32'd0);
      rst = 1'b0;

      // active video: no grant, then vblank opens
      bus.vcounter = 10'd100; bus.hcounter = 10'd10; bus.req = 3'b001;
      repeat (4) cyc();
      bus.vcounter = 10'd480;
      push_g(cyc_cnt + 1, 3'b001, A0, D0);
      cyc();
      bus.req = 3'b000;
      cyc(); cyc();

      // round robin from a fresh reset
      rst = 1'b1; cyc(); rst = 1'b0;
      bus.vcounter = 10'd490; bus.hcounter = 10'd100; bus.req = 3'b111;
      push_g(cyc_cnt + 1, 3'b001, A0, D0);
      push_g(cyc_cnt + 3, 3'b010, A1, D1);
      push_g(cyc_cnt + 5, 3'b100, A2, D2);
      push_g(cyc_cnt + 7, 3'b001, A0, 16'h5A5A);
      cyc(); cyc();
      bus.req_data[15:0] = 16'h5A5A;
      repeat (5) cyc();
      bus.req = 3'b000;
      bus.req_data[15:0] = D0;
      cyc(); cyc();

      // frame tick with nothing pending
      bus.vcounter = 10'd479; bus.hcounter = 10'd799;
      push_t(cyc_cnt + 1, 1'b0);
      cyc();
      bus.vcounter = 10'd100; bus.hcounter = 10'd0;
      cyc(); cyc();

      // request in guard lines waits for next vblank and is late
      bus.vcounter = 10'd523; bus.hcounter = 10'd0; bus.req = 3'b010;
      repeat (3) cyc();
      bus.vcounter = 10'd479; bus.hcounter = 10'd799;
      push_t(cyc_cnt + 1, 1'b1);
      cyc();
      bus.vcounter = 10'd480; bus.hcounter = 10'd0;
      push_g(cyc_cnt + 1, 3'b010, A1, D1);
      cyc();
      bus.req = 3'b000;
      cyc(); cyc();

      // grant on the last window cycle, completes outside the window
      bus.vcounter = 10'd522; bus.hcounter = 10'd799; bus.req = 3'b100;
      push_g(cyc_cnt + 1, 3'b100, A2, D2);
      cyc();
      bus.vcounter = 10'd523; bus.hcounter = 10'd0;
      repeat (4) cyc();
      bus.req = 3'b000;
      cyc();

      // reset during WRITE
      bus.vcounter = 10'd490; bus.hcounter = 10'd0; bus.req = 3'b100;
      push_g(cyc_cnt + 1, 3'b100, A2, D2);
      cyc();
      rst = 1'b1;
      cyc();
      chk("rstw_grant", 32'(bus.grant), 32'd0);
      chk("rstw_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rstw_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rstw_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      rst = 1'b0;
      push_g(cyc_cnt + 1, 3'b100, A2, D2);
      cyc();
      bus.req = 3'b000;
      cyc(); cyc();

      // hblank on an active line
      bus.vcounter = 10'd100; bus.hcounter = 10'd650; bus.req = 3'b010;
`ifdef VGA_ARB_HBLANK_EN
      push_g(cyc_cnt + 1, 3'b010, A1, D1);
`endif
      cyc();
      bus.hcounter = 10'd796;
      repeat (3) cyc();
      bus.req = 3'b000;
      repeat (3) cyc();

      chk("grant_queue_drained", 32'(gq.size()), 32'd0);
      chk("tick_queue_drained", 32'(tq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
